// File: rtl/pipe_hazard_if.sv
// Hazard-control signal bundle between the pipeline datapath and pipe_hazard_ctrl.
// The slave side is the controller; the master side is whatever drives the pipeline.
interface pipe_hazard_if;
    logic [4:0]  id_rs_i;
    logic [4:0]  id_rt_i;
    logic        id_uses_rt_i;
    logic        ex_memread_i;
    logic [4:0]  ex_rt_i;
    logic        ex_valid_i;
    logic        branch_taken_i;
    logic        dmem_req_i;
    logic        dmem_ack_i;
    logic        halt_clr_i;
    logic        pc_write_o;
    logic        if_id_write_o;
    logic        if_id_flush_o;
    logic        id_ex_enable_o;
    logic        pipe_hold_o;
    logic        err_o;
    logic [1:0]  state_o;
    logic [15:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;

    modport slave (
        input  id_rs_i, id_rt_i, id_uses_rt_i, ex_memread_i, ex_rt_i, ex_valid_i,
               branch_taken_i, dmem_req_i, dmem_ack_i, halt_clr_i,
        output pc_write_o, if_id_write_o, if_id_flush_o, id_ex_enable_o,
               pipe_hold_o, err_o, state_o, stall_cnt_o, flush_cnt_o
    );

    modport master (
        output id_rs_i, id_rt_i, id_uses_rt_i, ex_memread_i, ex_rt_i, ex_valid_i,
               branch_taken_i, dmem_req_i, dmem_ack_i, halt_clr_i,
        input  pc_write_o, if_id_write_o, if_id_flush_o, id_ex_enable_o,
               pipe_hold_o, err_o, state_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: memory-wait hold, branch flush and
// load-use bubble insertion, plus a memory-timeout FSM and event counters.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic         clk_i,
    input  logic         rst_n,
    pipe_hazard_if.slave hz
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_HALT     = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_cnt_nxt;
    logic        r_err;
    logic        w_err_nxt;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    logic        w_mem_stall;
    logic        w_hold;
    logic        w_rt_hit;
    logic        w_lu;
    logic        w_flush_ev;
    logic        w_stall_ev;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // An outstanding access without ack freezes everything; HALT ignores dmem entirely.
    always_comb begin
        w_mem_stall = hz.dmem_req_i & ~hz.dmem_ack_i & (r_state != S_HALT);
        w_hold      = (r_state == S_HALT) | w_mem_stall;
        w_rt_hit    = (hz.ex_rt_i == hz.id_rs_i) |
                      (hz.id_uses_rt_i & (hz.ex_rt_i == hz.id_rt_i));
        w_lu        = hz.ex_memread_i & hz.ex_valid_i & (hz.ex_rt_i != 5'd0) & w_rt_hit;
        w_flush_ev  = ~w_hold & hz.branch_taken_i;
        w_stall_ev  = ~w_hold & ~hz.branch_taken_i & w_lu;
    end

    always_comb begin
        hz.pc_write_o     = 1'b1;
        hz.if_id_write_o  = 1'b1;
        hz.if_id_flush_o  = 1'b0;
        hz.id_ex_enable_o = 1'b1;
        hz.pipe_hold_o    = 1'b0;
        if (w_hold) begin
            hz.pc_write_o     = 1'b0;
            hz.if_id_write_o  = 1'b0;
            hz.pipe_hold_o    = 1'b1;
        end else if (hz.branch_taken_i) begin
            hz.if_id_flush_o  = 1'b1;
            hz.id_ex_enable_o = 1'b0;
        end else if (w_lu) begin
            hz.pc_write_o     = 1'b0;
            hz.if_id_write_o  = 1'b0;
            hz.id_ex_enable_o = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_err_nxt      = r_err;
        case (r_state)
            S_RUN: begin
                if (hz.dmem_req_i & ~hz.dmem_ack_i) begin
                    w_state_nxt    = S_MEM_WAIT;
                    w_wait_cnt_nxt = 8'd1;
                end
            end
            S_MEM_WAIT: begin
                if (hz.dmem_ack_i) begin
                    w_state_nxt    = S_RUN;
                    w_wait_cnt_nxt = 8'd0;
                end else if (r_wait_cnt == TIMEOUT) begin
                    w_state_nxt    = S_HALT;
                    w_err_nxt      = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                end
            end
            S_HALT: begin
                if (hz.halt_clr_i) begin
                    w_state_nxt    = S_RUN;
                    w_wait_cnt_nxt = 8'd0;
                    w_err_nxt      = 1'b0;
                end
            end
            default: begin
                w_state_nxt    = S_RUN;
                w_wait_cnt_nxt = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_RUN;
            r_wait_cnt <= 8'd0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_err      <= w_err_nxt;
        end
    end

    // Only events that actually took effect are counted; both saturate.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            if (w_stall_ev) r_stall_cnt <= sat_inc(r_stall_cnt);
            if (w_flush_ev) r_flush_cnt <= sat_inc(r_flush_cnt);
        end
    end

    assign hz.err_o       = r_err;
    assign hz.state_o     = r_state;
    assign hz.stall_cnt_o = r_stall_cnt;
    assign hz.flush_cnt_o = r_flush_cnt;

endmodule
